mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit memory words (power of 2, 2..65536).
REQ-002 The block SHALL have parameter LATENCY, default 2: cycles from request sample to response (1..15).
REQ-003 The block SHALL have input clk, 1 bit: clock; all state changes on its rising edge.
REQ-004 The block SHALL have input reset, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have input mem_read, 1 bit: read request from the control unit.
REQ-006 The block SHALL have input mem_write, 1 bit: write request from the control unit.
REQ-007 The block SHALL have input addr, 32 bits: byte address selected by the control unit's IorD mux.
REQ-008 The block SHALL have input wdata, 32 bits: store data.
REQ-009 The block SHALL have output rdata, 32 bits, registered: last read data.
REQ-010 The block SHALL have output ready, 1 bit, registered: one-cycle pulse marking access completion.
REQ-011 The block SHALL have output busy, 1 bit, registered: high while an access is in progress.
REQ-012 The block SHALL have output err, 1 bit, registered: error flag, valid only while ready is high.

Function
REQ-013 The FSM SHALL have 3 states: IDLE, WAIT and DONE.
REQ-014 In IDLE, (mem_read | mem_write) high at edge k SHALL latch addr, wdata and the operation, set busy=1, load the counter with LATENCY-1, and move to WAIT.
REQ-015 In WAIT, the counter SHALL decrement each edge; at 0 the access SHALL be performed, ready=1 SHALL be set, and the FSM SHALL move to DONE, so ready is first visible after edge k+LATENCY.
REQ-016 In DONE, the next edge SHALL clear ready and busy and return to IDLE; back-to-back requests therefore start no earlier than edge k+LATENCY+1.
REQ-017 Request inputs SHALL be ignored while busy=1; requests are not queued.
REQ-018 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; upper address bits SHALL be ignored, so addresses alias and wrap modulo 4*DEPTH_WORDS.
REQ-019 A write SHALL commit mem[index]<=latched wdata on the completion edge; the memory SHALL be unchanged before that edge.
REQ-020 A read SHALL load rdata<=mem[index] on the completion edge, and rdata SHALL hold until the next completed read; writes SHALL NOT change rdata.
REQ-021 A read following a completed write to the same index SHALL return the new data.
REQ-022 If mem_read and mem_write are sampled high together, the access SHALL be a read and the write SHALL be dropped.
REQ-023 err SHALL be 0 except as defined under Configuration.

Reset
REQ-024 Reset SHALL set state=IDLE, ready=0, busy=0, err=0, rdata=0 and counter=0.
REQ-025 Reset SHALL NOT clear memory contents.
REQ-026 Reset asserted mid-access SHALL abort the access: no memory write, no ready pulse, and rdata=0.
REQ-027 A request held high during the reset cycle SHALL NOT be sampled; sampling SHALL resume at the first edge with reset low.

Configuration
REQ-028 With macro MEM_RESPONDER_MISALIGN_CHECK_EN defined, a request with addr[1:0]!=0 SHALL complete with normal timing, ready=1 and err=1, with no memory write and rdata unchanged.
REQ-029 Without MEM_RESPONDER_MISALIGN_CHECK_EN, addr[1:0] SHALL be ignored, the access SHALL proceed on the truncated word index, and err SHALL be tied to 0.

Verification
REQ-030 With LATENCY=2: write 0xDEADBEEF to addr 0x10, then read 0x10 -> ready is seen 2 edges after each sample, and rdata=0xDEADBEEF.
REQ-031 With DEPTH_WORDS=256: write 0x12345678 to addr 0x404, then read 0x004 -> rdata=0x12345678 (alias/wrap).
REQ-032 Read with mem_read and mem_write both high, wdata=0xFFFFFFFF at addr 0x20 (previously 0x0) -> rdata=0x0, and a re-read also returns 0x0.
REQ-033 Start a write of 0xAAAA5555 to 0x30, then assert reset at edge k+1 -> no ready pulse, busy=0, and a subsequent read of 0x30 returns the old value.
REQ-034 Pulse mem_read during busy at a second address -> it is ignored, exactly one ready pulse occurs, and rdata reflects the first address.
REQ-035 With the macro defined, read addr 0x13 -> ready=1, err=1, rdata unchanged; without the macro, the same read returns mem[4] with err=0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency single-port word memory behind a simple read/write request handshake.
//
// Ports:
//   clk        - clock; all state changes on its rising edge
//   reset      - synchronous active-high reset (memory contents are kept)
//   mem_read   - read request, sampled only while idle
//   mem_write  - write request, sampled only while idle (a read wins if both are high)
//   addr       - byte address; word index is addr[log2(DEPTH_WORDS)+1:2], upper bits alias
//   wdata      - store data
//   rdata      - last completed read data (registered)
//   ready      - one-cycle completion pulse (registered)
//   busy       - access in progress (registered)
//   err        - misaligned-access flag, meaningful only with ready (registered)
//
// Optional feature: define MEM_RESPONDER_MISALIGN_CHECK_EN to report accesses with
// addr[1:0] != 0 through err instead of performing them. Without it err stays 0.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rd_q, rd_d;
    logic          mis_q, mis_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          req, mis_req, fire;
    logic [31:0]   mem [DEPTH_WORDS];

`ifdef MEM_RESPONDER_MISALIGN_CHECK_EN
    assign mis_req = |addr[1:0];
`else
    assign mis_req = 1'b0;
`endif

    // Address bits outside the word index never influence the access.
    logic unused_addr;
    assign unused_addr = ^{addr[31:IW+2], addr[1:0]};

    assign req  = mem_read | mem_write;
    assign fire = (state_q == WAIT) && (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        mis_d   = mis_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: if (req) begin
                state_d = WAIT;
                cnt_d   = 4'(LATENCY - 1);
                idx_d   = addr[IW+1:2];
                wdata_d = wdata;
                rd_d    = mem_read;
                mis_d   = mis_req;
            end
            WAIT: if (cnt_q == 4'd0) begin
                state_d = DONE;
                ready_d = 1'b1;
                err_d   = mis_q;
                rdata_d = (rd_q && !mis_q) ? mem[idx_q] : rdata_q;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            rd_q    <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Memory has no reset; a reset on the completion edge aborts the write.
    always_ff @(posedge clk) begin
        if (!reset && fire && !rd_q && !mis_q) mem[idx_q] <= wdata_q;
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = err_q;
endmodule
